// File: rtl/hoplite_sched_router.sv
// hoplite_sched_router
//   Schedule-driven Hoplite-style switch for the DDR-to-PE distribution
//   fabric. While a run is active, one step is issued per cycle. Each step
//   reads schedule entry[cnt] and routes the registered north (DDR) and west
//   words to the east and PE outputs. Results leave through a mux register
//   and PIPENUM further pipeline stages. A step issued in cycle T is presented
//   on the ports in cycle T+2+PIPENUM.
//
//   Ports
//     clk, rst           single clock, synchronous active-high reset
//     n_in, w_in         north / west data, sampled when a step is issued
//     cfg_we/addr/data   schedule write port; entry [1:0]=east sel, [3:2]=PE sel
//     cfg_err            one-cycle pulse after a write dropped because busy
//     sched_len, loop    run length and wrap mode, sampled with start
//     start, stop        begin a run / end a looping run after the current step
//     e_out, e_valid     east output word and its valid flag
//     pe_out, pe_valid   PE output word and its valid flag
//     busy, done         run in progress / sticky completion flag
//
//   Select encoding: 00 = west, 01 = north, 1x = none (data 0, valid 0).
module hoplite_sched_router #(
   parameter int D_W         = 512,
   parameter int PIPENUM     = 4,
   parameter int SCHED_DEPTH = 16,
   parameter int AW          = $clog2(SCHED_DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [D_W-1:0] n_in,
   input  logic [D_W-1:0] w_in,
   input  logic           cfg_we,
   input  logic [AW-1:0]  cfg_addr,
   input  logic [3:0]     cfg_data,
   output logic           cfg_err,
   input  logic [AW:0]    sched_len,
   input  logic           loop,
   input  logic           start,
   input  logic           stop,
   output logic [D_W-1:0] e_out,
   output logic           e_valid,
   output logic [D_W-1:0] pe_out,
   output logic           pe_valid,
   output logic           busy,
   output logic           done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   localparam logic [3:0] ENTRY_NONE = 4'b1010;
   localparam logic [AW:0] DEPTH     = (AW+1)'(SCHED_DEPTH);

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [AW:0]     len_q, len_d;
   logic            loop_q, loop_d;
   logic            cfg_err_q;

   logic [3:0]      sched_q [SCHED_DEPTH];

   // Stage 1: registered inputs and select of the issued step (or a bubble).
   logic [D_W-1:0]  n_s1_q, w_s1_q;
   logic [3:0]      sel_s1_q;

   // Data/valid after the mux register: index 0 is the mux register and
   // index PIPENUM drives the ports.
   logic [D_W-1:0]  e_q  [0:PIPENUM];
   logic [D_W-1:0]  pe_q [0:PIPENUM];
   logic            ev_q [0:PIPENUM];
   logic            pv_q [0:PIPENUM];

   // Last-step tag: index 0 is stage 1, index k is one stage later than k-1.
   // last_q[PIPENUM] is the stage just before the ports, so seeing it lets
   // DONE be entered exactly when the last word is presented.
   logic            last_q [0:PIPENUM];

   logic            issue, issue_last, at_end, busy_int;
   logic [AW:0]     len_m1;
   logic [3:0]      cur_entry;
   logic [D_W-1:0]  e_mux, pe_mux;
   logic            e_mux_v, pe_mux_v;

   assign busy_int  = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign len_m1    = len_q - (AW+1)'(1);
   assign at_end    = ({1'b0, cnt_q} == len_m1);
   assign cur_entry = sched_q[cnt_q];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      loop_d     = loop_q;
      issue      = 1'b0;
      issue_last = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               len_d   = (sched_len > DEPTH) ? DEPTH : sched_len;
               loop_d  = loop;
               cnt_d   = '0;
               state_d = (sched_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            issue      = 1'b1;
            issue_last = stop || (!loop_q && at_end);
            if (issue_last) begin
               state_d = S_DRAIN;
            end else begin
               cnt_d = at_end ? '0 : cnt_q + AW'(1);
            end
         end
         S_DRAIN: begin
            if (last_q[PIPENUM]) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- schedule
   // NOTE: the schedule memory is reset on purpose: every entry must read
   // "none" after rst, so it is built from flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SCHED_DEPTH; i++) sched_q[i] <= ENTRY_NONE;
         cfg_err_q <= 1'b0;
      end else begin
         if (cfg_we && !busy_int) sched_q[cfg_addr] <= cfg_data;
         cfg_err_q <= cfg_we && busy_int;
      end
   end

   // ---------------------------------------------------------------- mux
   always_comb begin
      e_mux    = '0;
      e_mux_v  = 1'b0;
      pe_mux   = '0;
      pe_mux_v = 1'b0;
      unique case (sel_s1_q[1:0])
         2'b00:   begin e_mux = w_s1_q; e_mux_v = 1'b1; end
         2'b01:   begin e_mux = n_s1_q; e_mux_v = 1'b1; end
         default: ;
      endcase
      unique case (sel_s1_q[3:2])
         2'b00:   begin pe_mux = w_s1_q; pe_mux_v = 1'b1; end
         2'b01:   begin pe_mux = n_s1_q; pe_mux_v = 1'b1; end
         default: ;
      endcase
   end

   // ----------------------------------------------------------- pipeline
   // NOTE: non-blocking assignments let each stage read its neighbour's
   // previous value, so the shift loop below is order-independent.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_s1_q   <= '0;
         w_s1_q   <= '0;
         sel_s1_q <= ENTRY_NONE;
         for (int i = 0; i <= PIPENUM; i++) begin
            e_q[i]    <= '0;
            pe_q[i]   <= '0;
            ev_q[i]   <= 1'b0;
            pv_q[i]   <= 1'b0;
            last_q[i] <= 1'b0;
         end
      end else begin
         // Outside RUN a zero bubble with select "none" enters stage 1.
         n_s1_q    <= issue ? n_in : '0;
         w_s1_q    <= issue ? w_in : '0;
         sel_s1_q  <= issue ? cur_entry : ENTRY_NONE;
         last_q[0] <= issue_last;

         e_q[0]  <= e_mux;
         pe_q[0] <= pe_mux;
         ev_q[0] <= e_mux_v;
         pv_q[0] <= pe_mux_v;
         for (int i = 1; i <= PIPENUM; i++) begin
            e_q[i]    <= e_q[i-1];
            pe_q[i]   <= pe_q[i-1];
            ev_q[i]   <= ev_q[i-1];
            pv_q[i]   <= pv_q[i-1];
            last_q[i] <= last_q[i-1];
         end
      end
   end

   assign e_out    = e_q[PIPENUM];
   assign e_valid  = ev_q[PIPENUM];
   assign pe_out   = pe_q[PIPENUM];
   assign pe_valid = pv_q[PIPENUM];
   assign busy     = busy_int;
   assign done     = (state_q == S_DONE);
   assign cfg_err  = cfg_err_q;

endmodule
